rr_mux_nx1: RTL and testbench
=============================

// Module: rr_mux_nx1
// PURPOSE
//   Registered N-to-1 data multiplexer with per-channel valid/ready handshake and round-robin
//   arbitration. Successor to the combinational Nx1 mux: the select line is generated internally
//   from channel requests rather than supplied by the user. Sits wherever several producers share
//   one downstream consumer, e.g. bus concentrators and result-merge points.
// PARAMETERS
//   N      8  number of input channels (N >= 1; need not be a power of two)
//   WIDTH  8  data width per channel, in bits
//   SEL_W  derived localparam = (N > 1) ? $clog2(N) : 1; not overridable
// PORTS
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous reset, active low
//   in_data    in   N*WIDTH  concatenated channel data; channel i = in_data[i*WIDTH +: WIDTH]
//   in_valid   in   N        channel i presents a beat
//   in_ready   out  N        channel i beat accepted this cycle (one-hot or zero)
//   out_data   out  WIDTH    registered output beat
//   out_sel    out  SEL_W    index of the channel that supplied out_data
//   out_valid  out  1        out_data/out_sel hold a beat
//   out_ready  in   1        consumer accepts the beat
// BEHAVIOUR
//   - Reset (async assert, sync deassert edge): out_valid=0, out_data=0, out_sel=0, rr pointer ptr=0.
//   - load = !out_valid || out_ready. Single output register; full throughput, no bubbles.
//   - Arbitration (combinational): grant = first i with in_valid[i], searching ptr, ptr+1, ...,
//     N-1, 0, ..., ptr-1. No in_valid set -> no grant.
//   - in_ready[i] = load && grant[i]. At most one bit set. in_ready depends combinationally on
//     out_ready and in_valid; in_valid must not depend on in_ready.
//   - Transfer on channel g (in_valid[g] && in_ready[g]): next edge out_data<=in_data[g],
//     out_sel<=g, out_valid<=1, ptr<=(g==N-1)?0:g+1. Latency: 1 clock from accept to out_valid.
//   - load && no grant: out_valid<=0; out_data, out_sel, ptr hold.
//   - !load (out_valid && !out_ready): out_data, out_sel, out_valid, ptr all hold; every in_ready=0.
//   - Simultaneous drain and refill (out_valid && out_ready && grant): new beat loads the same
//     edge; out_valid stays 1.
//   - Wrap: ptr increments modulo N (for N=6, 5 -> 0); ptr never reaches N.
//   - N=1: ptr and out_sel constant 0; block behaves as a one-stage pipeline register.
//   - Fairness: with all channels continuously valid and out_ready=1, grants cycle 0,1,...,N-1,0...
//   - Reset mid-operation: a held beat is discarded; out_valid drops asynchronously.
//   - Producers must hold in_data/in_valid until accepted; the block does not check this.
// CONFIGURATION
//   RR_MUX_FIXED_PRIO_EN
//     defined:   fixed priority; grant = lowest-index channel with in_valid set; ptr is neither
//                implemented nor updated. All other behaviour unchanged.
//     undefined: round-robin as described above (default).
// TESTING  (N=4, WIDTH=8 unless noted)
//   1. Reset: rst_n=0 mid-beat with out_valid=1 -> out_valid=0, out_data=00, out_sel=0 at once.
//   2. Single channel: in_valid=4'b0100, in_data[23:16]=A5, out_ready=1 -> in_ready=4'b0100;
//      next cycle out_valid=1, out_data=A5, out_sel=2.
//   3. Round-robin: in_valid=4'b1111, data = channel index + 10, out_ready=1 for 8 cycles ->
//      out_sel sequence 0,1,2,3,0,1,2,3; out_data 10,11,12,13,10,... (FIXED_PRIO_EN: all 0, data 10).
//   4. Backpressure: beat out_data=3C held, out_ready=0 for 5 cycles, in_valid=4'b0011 ->
//      in_ready=0, out_data=3C stable; on out_ready=1 the same-cycle refill loads next winner.
//   5. Wrap, N=6: ptr=5, in_valid=6'b100001 -> grant 5, then 0; ptr wraps 5->0, out_sel 5 then 0.
//   6. Idle drain: single beat accepted, then in_valid=0, out_ready=1 -> out_valid drops after 1
//      cycle; out_data and out_sel retain their last values.

Source files
------------

// File: rtl/rr_mux_nx1_if.sv
// Handshake bundle for rr_mux_nx1: N producer channels merged onto a single consumer.
// The slave modport is the mux side; the master modport is the producers/consumer side.
interface rr_mux_nx1_if #(
   parameter int N     = 8,
   parameter int WIDTH = 8
) ();
   localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_valid;
   logic [N-1:0]       in_ready;
   logic [WIDTH-1:0]   out_data;
   logic [SEL_W-1:0]   out_sel;
   logic               out_valid;
   logic               out_ready;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_sel, out_valid
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_sel, out_valid
   );
endinterface

// File: rtl/rr_mux_nx1.sv
// Registered N-to-1 mux with per-channel valid/ready and round-robin arbitration.
// Define RR_MUX_FIXED_PRIO_EN for fixed lowest-index priority (no rotating pointer).
module rr_mux_nx1 #(
   parameter int N     = 8,
   parameter int WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   rr_mux_nx1_if.slave    bus
);
   localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

   logic             load;
   logic             hi_any;
   logic             lo_any;
   logic [SEL_W-1:0] hi_idx;
   logic [SEL_W-1:0] lo_idx;
   logic             gnt_any;
   logic [SEL_W-1:0] gnt_idx;
   logic [WIDTH-1:0] gnt_data;

   logic [WIDTH-1:0] data_q;
   logic [SEL_W-1:0] sel_q;
   logic             valid_q;

`ifndef RR_MUX_FIXED_PRIO_EN
   logic [SEL_W-1:0] ptr;
`endif

   assign load = !valid_q || bus.out_ready;

   // Channels at or above ptr outrank those below it; descending scan leaves the lowest in each group.
   always_comb begin
      hi_any = 1'b0;
      lo_any = 1'b0;
      hi_idx = '0;
      lo_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (bus.in_valid[i]) begin
`ifdef RR_MUX_FIXED_PRIO_EN
            hi_any = 1'b1;
            hi_idx = SEL_W'(i);
`else
            if (SEL_W'(i) >= ptr) begin
               hi_any = 1'b1;
               hi_idx = SEL_W'(i);
            end else begin
               lo_any = 1'b1;
               lo_idx = SEL_W'(i);
            end
`endif
         end
      end
      gnt_any = hi_any || lo_any;
      gnt_idx = hi_any ? hi_idx : lo_idx;
   end

   always_comb begin
      gnt_data     = '0;
      bus.in_ready = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt_idx == SEL_W'(i)) begin
            gnt_data        = bus.in_data[i*WIDTH +: WIDTH];
            bus.in_ready[i] = load && gnt_any;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         sel_q   <= '0;
         valid_q <= 1'b0;
      end else if (load) begin
         if (gnt_any) begin
            data_q  <= gnt_data;
            sel_q   <= gnt_idx;
            valid_q <= 1'b1;
         end else begin
            valid_q <= 1'b0;
         end
      end
   end

`ifndef RR_MUX_FIXED_PRIO_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (load && gnt_any) begin
         ptr <= (gnt_idx == SEL_W'(N - 1)) ? '0 : gnt_idx + SEL_W'(1);
      end
   end
`endif

   assign bus.out_data  = data_q;
   assign bus.out_sel   = sel_q;
   assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_rr_mux_nx1.sv
// Directed bench for rr_mux_nx1: a 4-channel instance for most cases, a 6-channel one for wrap.
module tb_rr_mux_nx1;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   rr_mux_nx1_if #(.N(4), .WIDTH(8)) a_if ();
   rr_mux_nx1_if #(.N(6), .WIDTH(8)) b_if ();

   rr_mux_nx1 #(.N(4), .WIDTH(8)) u_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
   rr_mux_nx1 #(.N(6), .WIDTH(8)) u_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int g;
      rst_n          = 1'b0;
      a_if.in_valid  = '0;
      a_if.in_data   = '0;
      a_if.out_ready = 1'b0;
      b_if.in_valid  = '0;
      b_if.in_data   = '0;
      b_if.out_ready = 1'b0;

      #12;
      chk("rst_valid", 32'(a_if.out_valid), 32'd0);
      chk("rst_data",  32'(a_if.out_data),  32'h00);
      chk("rst_sel",   32'(a_if.out_sel),   32'd0);
      chk("rst_ready", 32'(a_if.in_ready),  32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // single channel, then idle drain
      a_if.in_data[23:16] = 8'hA5;
      a_if.in_valid       = 4'b0100;
      a_if.out_ready      = 1'b1;
      #1;
      chk("single_ready", 32'(a_if.in_ready), 32'b0100);
      tick();
      chk("single_valid", 32'(a_if.out_valid), 32'd1);
      chk("single_data",  32'(a_if.out_data),  32'hA5);
      chk("single_sel",   32'(a_if.out_sel),   32'd2);
      a_if.in_valid = 4'b0000;
      #1;
      chk("idle_ready", 32'(a_if.in_ready), 32'h0);
      tick();
      chk("drain_valid", 32'(a_if.out_valid), 32'd0);
      chk("drain_data",  32'(a_if.out_data),  32'hA5);
      chk("drain_sel",   32'(a_if.out_sel),   32'd2);

      // fresh pointer, then all channels valid
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      a_if.in_data  = {8'd13, 8'd12, 8'd11, 8'd10};
      a_if.in_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
`ifdef RR_MUX_FIXED_PRIO_EN
         g = 0;
`else
         g = k % 4;
`endif
         #1;
         chk($sformatf("rr_ready%0d", k), 32'(a_if.in_ready), 32'(1 << g));
         tick();
         chk($sformatf("rr_sel%0d", k),  32'(a_if.out_sel),  32'(g));
         chk($sformatf("rr_data%0d", k), 32'(a_if.out_data), 32'(10 + g));
      end

      // backpressure with a held 3C beat
      a_if.in_data[15:8] = 8'h3C;
      a_if.in_valid      = 4'b0010;
      #1;
      chk("bp_load_ready", 32'(a_if.in_ready), 32'b0010);
      tick();
      chk("bp_load_data", 32'(a_if.out_data), 32'h3C);
      chk("bp_load_sel",  32'(a_if.out_sel),  32'd1);
      a_if.out_ready = 1'b0;
      a_if.in_data   = {8'd13, 8'd12, 8'h41, 8'h40};
      a_if.in_valid  = 4'b0011;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk($sformatf("bp_ready%0d", k), 32'(a_if.in_ready),  32'h0);
         chk($sformatf("bp_data%0d", k),  32'(a_if.out_data),  32'h3C);
         chk($sformatf("bp_valid%0d", k), 32'(a_if.out_valid), 32'd1);
         tick();
      end
      a_if.out_ready = 1'b1;
      #1;
      chk("refill_ready", 32'(a_if.in_ready), 32'b0001);
      tick();
      chk("refill_data",  32'(a_if.out_data),  32'h40);
      chk("refill_sel",   32'(a_if.out_sel),   32'd0);
      chk("refill_valid", 32'(a_if.out_valid), 32'd1);
      a_if.in_valid  = 4'b0010;
      a_if.out_ready = 1'b0;

      // asynchronous reset while a beat is held
      #2 rst_n = 1'b0;
      #1;
      chk("async_valid", 32'(a_if.out_valid), 32'd0);
      chk("async_data",  32'(a_if.out_data),  32'h00);
      chk("async_sel",   32'(a_if.out_sel),   32'd0);
      a_if.in_valid = 4'b0000;
      #2 rst_n = 1'b1;

      // N=6 wrap: reach ptr=5 via channel 4, then 5 and 0 both valid
      tick();
      b_if.in_data   = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'h60};
      b_if.in_valid  = 6'b010000;
      b_if.out_ready = 1'b1;
      #1;
      chk("wrap_pre_ready", 32'(b_if.in_ready), 32'b010000);
      tick();
      chk("wrap_pre_sel", 32'(b_if.out_sel), 32'd4);
      b_if.in_valid = 6'b100001;
      #1;
`ifdef RR_MUX_FIXED_PRIO_EN
      chk("wrap5_ready", 32'(b_if.in_ready), 32'b000001);
      tick();
      chk("wrap5_sel",  32'(b_if.out_sel),  32'd0);
      chk("wrap5_data", 32'(b_if.out_data), 32'h60);
`else
      chk("wrap5_ready", 32'(b_if.in_ready), 32'b100000);
      tick();
      chk("wrap5_sel",  32'(b_if.out_sel),  32'd5);
      chk("wrap5_data", 32'(b_if.out_data), 32'h55);
`endif
      #1;
      chk("wrap0_ready", 32'(b_if.in_ready), 32'b000001);
      tick();
      chk("wrap0_sel",  32'(b_if.out_sel),  32'd0);
      chk("wrap0_data", 32'(b_if.out_data), 32'h60);
      b_if.in_valid = 6'b000000;
      tick();
      chk("wrap_drain_valid", 32'(b_if.out_valid), 32'd0);
      chk("wrap_drain_sel",   32'(b_if.out_sel),   32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
